// File: rtl/rv32i_pipelined_dual_port_ram_if.sv
// Bus bundle for the dual-port RV32I RAM: instruction read port and data read/write port.
// The master drives requests; the slave (the RAM) returns ready, valid and read data.
interface rv32i_pipelined_dual_port_ram_if #(
   parameter int ADDR_WIDTH = 15
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ready;
   logic                  i_valid;
   logic [31:0]           i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [3:0]            d_be;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [31:0]           d_wdata;
   logic                  d_ready;
   logic                  d_valid;
   logic [31:0]           d_rdata;

   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
      input  i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
      output i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata
   );
endinterface

// File: rtl/rv32i_pipelined_dual_port_ram.sv
// Dual-port word RAM: instruction read port plus byte-enabled data read/write port,
// 1- or 2-cycle read pipeline, optional storage byte swap and zero-fill after reset.
module rv32i_pipelined_dual_port_ram #(
   parameter int ADDR_WIDTH     = 15,
   parameter int RD_LATENCY     = 1,
   parameter bit BYTE_SWAP      = 1'b1,
   parameter bit CLEAR_ON_RESET = 1'b0,
   parameter     INIT_FILE      = "ram.hex"
) (
   input logic clk,
   input logic reset_n,
   rv32i_pipelined_dual_port_ram_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  ready;
   logic                  clr_we;

   logic [31:0] mem [DEPTH];

   logic        i_acc;
   logic        d_rd;
   logic        d_wr;
   logic [3:0]  be_store;
   logic [31:0] wdata_store;

   logic        i_v1;
   logic        d_v1;
   logic [31:0] i_d1;
   logic [31:0] d_d1;

   // Byte reversal is its own inverse, so one helper serves both directions.
   function automatic logic [31:0] swap_word(input logic [31:0] w);
      return BYTE_SWAP ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
   endfunction

   function automatic logic [3:0] swap_be(input logic [3:0] be);
      return BYTE_SWAP ? {be[0], be[1], be[2], be[3]} : be;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= CLEAR_ON_RESET ? CLEAR : READY;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
         end
      end
   end

   // Ready is gated by reset_n so the ports stay closed while reset is held.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      clr_we     = 1'b0;
      case (state)
         CLEAR: begin
            clr_we = reset_n;
            if (clr_cnt == '1) begin
               state_next = READY;
            end
         end
         READY: begin
            ready = reset_n;
         end
         default: state_next = state;
      endcase
   end

   assign i_acc       = bus.i_req & ready;
   assign d_rd        = bus.d_req & ready & ~bus.d_we;
   assign d_wr        = bus.d_req & ready & bus.d_we;
   assign be_store    = swap_be(bus.d_be);
   assign wdata_store = swap_word(bus.d_wdata);

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_cnt] <= '0;
      end else if (d_wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be_store[b]) begin
               mem[bus.d_addr][8*b +: 8] <= wdata_store[8*b +: 8];
            end
         end
      end
   end

   // Reads sample the array before this edge's write lands: read-before-write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_v1 <= 1'b0;
         d_v1 <= 1'b0;
         i_d1 <= '0;
         d_d1 <= '0;
      end else begin
         i_v1 <= i_acc;
         d_v1 <= d_rd;
         if (i_acc) begin
            i_d1 <= swap_word(mem[bus.i_addr]);
         end
         if (d_rd) begin
            d_d1 <= swap_word(mem[bus.d_addr]);
         end
      end
   end

   generate
      if (RD_LATENCY == 1) begin : g_lat1
         assign bus.i_valid = i_v1;
         assign bus.i_rdata = i_d1;
         assign bus.d_valid = d_v1;
         assign bus.d_rdata = d_d1;
      end else if (RD_LATENCY == 2) begin : g_lat2
         logic        i_v2;
         logic        d_v2;
         logic [31:0] i_d2;
         logic [31:0] d_d2;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               i_v2 <= 1'b0;
               d_v2 <= 1'b0;
               i_d2 <= '0;
               d_d2 <= '0;
            end else begin
               i_v2 <= i_v1;
               d_v2 <= d_v1;
               if (i_v1) begin
                  i_d2 <= i_d1;
               end
               if (d_v1) begin
                  d_d2 <= d_d1;
               end
            end
         end

         assign bus.i_valid = i_v2;
         assign bus.i_rdata = i_d2;
         assign bus.d_valid = d_v2;
         assign bus.d_rdata = d_d2;
      end else begin : g_bad_latency
         $error("RD_LATENCY must be 1 or 2");
      end
   endgenerate

   assign bus.i_ready = ready;
   assign bus.d_ready = ready;
endmodule
